cpu_sequencer: RTL

//  Parametrised multi-cycle control sequencer for the cpu core: owns PC, instruction register and memory handshake.

---
 rtl/cpu_sequencer.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer: owns PC, instruction register and the memory handshake,
// stepping FETCH/DECODE/EXEC/MEM/WB with wait-state timeout and sticky HALT/ERR.
module cpu_sequencer #(
    parameter int unsigned           ADDR_WIDTH  = 32,
    parameter int unsigned           DATA_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
    parameter int unsigned           PC_STEP     = 1,
    parameter int unsigned           MAX_WAIT    = 15,
    parameter int unsigned           COUNT_WIDTH = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    output logic [DATA_WIDTH-1:0]  mem_wdata,
    input  logic [DATA_WIDTH-1:0]  mem_rdata,
    input  logic                   mem_ready,
    output logic [DATA_WIDTH-1:0]  instr,
    output logic                   decode_valid,
    output logic [ADDR_WIDTH-1:0]  pc,
    input  logic [1:0]             ex_mem_op,
    input  logic [ADDR_WIDTH-1:0]  ex_mem_addr,
    input  logic [DATA_WIDTH-1:0]  ex_wdata,
    input  logic                   ex_branch,
    input  logic [ADDR_WIDTH-1:0]  ex_target,
    input  logic                   ex_halt,
    output logic                   wb_en,
    output logic                   wb_load,
    output logic [DATA_WIDTH-1:0]  wb_data,
    output logic [2:0]             state_o,
    output logic                   halted,
    output logic                   timeout_err,
    output logic [COUNT_WIDTH-1:0] retire_count
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5,
        ERR    = 3'd6
    } state_t;

    localparam int unsigned           WAIT_W     = (MAX_WAIT == 0) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0]     WAIT_LIMIT = WAIT_W'(MAX_WAIT);
    localparam logic [ADDR_WIDTH-1:0] STEP       = ADDR_WIDTH'(PC_STEP);
    localparam logic [1:0]            OP_LOAD    = 2'b01;
    localparam logic [1:0]            OP_STORE   = 2'b10;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_pc;
    logic [ADDR_WIDTH-1:0]   r_next_pc;
    logic [DATA_WIDTH-1:0]   r_instr;
    logic [DATA_WIDTH-1:0]   r_wb_data;
    logic [COUNT_WIDTH-1:0]  r_retire;
    logic [WAIT_W-1:0]       r_wait;
    logic [1:0]              r_op;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic                    w_timeout;

    // A ready in the final allowed wait cycle still completes the access.
    assign w_timeout = (MAX_WAIT != 0) && (r_wait == WAIT_LIMIT) && !mem_ready;

    always_ff @(posedge clock) begin
        if (reset) r_state <= FETCH;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = r_pc;
        decode_valid = 1'b0;
        wb_en        = 1'b0;
        wb_load      = 1'b0;
        case (r_state)
            FETCH: begin
                mem_req = !reset;
                if (mem_ready)      w_state_nxt = DECODE;
                else if (w_timeout) w_state_nxt = ERR;
            end
            DECODE: begin
                decode_valid = !reset;
                w_state_nxt  = EXEC;
            end
            EXEC: begin
                if (ex_halt)                                         w_state_nxt = HALT;
                else if (ex_mem_op == OP_LOAD || ex_mem_op == OP_STORE) w_state_nxt = MEM;
                else                                                 w_state_nxt = WB;
            end
            MEM: begin
                mem_req  = !reset;
                mem_we   = (r_op == OP_STORE);
                mem_addr = r_addr;
                if (mem_ready)      w_state_nxt = WB;
                else if (w_timeout) w_state_nxt = ERR;
            end
            WB: begin
                wb_en       = !reset && (r_op != OP_STORE);
                wb_load     = (r_op == OP_LOAD);
                w_state_nxt = FETCH;
            end
            default: w_state_nxt = r_state;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc      <= RESET_PC;
            r_next_pc <= '0;
            r_instr   <= '0;
            r_wb_data <= '0;
            r_retire  <= '0;
            r_wait    <= '0;
            r_op      <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
        end else begin
            case (r_state)
                FETCH: begin
                    if (mem_ready) begin
                        r_instr <= mem_rdata;
                        r_wait  <= '0;
                    end else begin
                        r_wait  <= r_wait + 1'b1;
                    end
                end
                EXEC: begin
                    r_op      <= ex_mem_op;
                    r_addr    <= ex_mem_addr;
                    r_wdata   <= ex_wdata;
                    r_next_pc <= ex_branch ? ex_target : r_pc + STEP;
                    r_wait    <= '0;
                end
                MEM: begin
                    if (mem_ready) begin
                        if (r_op == OP_LOAD) r_wb_data <= mem_rdata;
                        r_wait <= '0;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                WB: begin
                    r_pc     <= r_next_pc;
                    r_retire <= r_retire + 1'b1;
                    r_wait   <= '0;
                end
                default: ;
            endcase
        end
    end

    assign mem_wdata    = r_wdata;
    assign instr        = r_instr;
    assign pc           = r_pc;
    assign wb_data      = r_wb_data;
    assign retire_count = r_retire;
    assign state_o      = r_state;
    assign halted       = (r_state == HALT);
    assign timeout_err  = (r_state == ERR);

endmodule
